// File: rtl/wave_period_analyzer.sv
// Measures the period (in valid samples) and min/max/peak-to-peak of a sampled waveform
// using rising midpoint crossings with hysteresis. Define WAVE_ANALYZER_SIGNED_EN for two's complement samples.
module wave_period_analyzer #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
`ifdef WAVE_ANALYZER_SIGNED_EN
  parameter int MIDPOINT   = 0,
`else
  parameter int MIDPOINT   = 128,
`endif
  parameter int HYST       = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sample_valid_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic                  clear_i,
  output logic                  result_valid_o,
  output logic [CNT_WIDTH-1:0]  period_o,
  output logic [DATA_WIDTH-1:0] max_o,
  output logic [DATA_WIDTH-1:0] min_o,
  output logic [DATA_WIDTH-1:0] pk_pk_o,
  output logic                  locked_o,
  output logic                  overflow_o
);

  // One extra bit lets the same signed compares serve both sample encodings.
  typedef logic signed [DATA_WIDTH:0] ext_t;

  localparam ext_t HI_THR = ext_t'(MIDPOINT + HYST);
  localparam ext_t LO_THR = ext_t'(MIDPOINT - HYST);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {SEEK, ARMED, MEASURE} state_t;

  function automatic ext_t ext(input logic [DATA_WIDTH-1:0] v);
`ifdef WAVE_ANALYZER_SIGNED_EN
    return ext_t'({v[DATA_WIDTH-1], v});
`else
    return ext_t'({1'b0, v});
`endif
  endfunction

  state_t                  state_reg, state_next;
  logic                    region_reg;
  logic                    have_result_reg;
  logic [CNT_WIDTH-1:0]    count_reg;
  logic [DATA_WIDTH-1:0]   run_min_reg, run_max_reg;
  logic                    result_valid_reg;
  logic [CNT_WIDTH-1:0]    period_reg;
  logic [DATA_WIDTH-1:0]   max_reg, min_reg, pk_pk_reg;
  logic                    locked_reg, overflow_reg;

  ext_t sample_ext;
  logic is_high, is_low, rising, at_max;
  logic start_cycle, emit_result, advance, saturate;

  assign sample_ext = ext(sample_i);
  assign is_high    = sample_ext >= HI_THR;
  assign is_low     = sample_ext <= LO_THR;
  assign rising     = sample_valid_i && !region_reg && is_high;
  assign at_max     = (count_reg == CNT_MAX);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) state_reg <= SEEK;
    else                  state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SEEK:    if (sample_valid_i && is_low) state_next = ARMED;
      ARMED:   if (rising) state_next = MEASURE;
      MEASURE: if (sample_valid_i && !rising && at_max) state_next = SEEK;
      default: state_next = SEEK;
    endcase
  end

  always_comb begin
    start_cycle = 1'b0;
    emit_result = 1'b0;
    advance     = 1'b0;
    saturate    = 1'b0;
    case (state_reg)
      ARMED:   start_cycle = rising;
      MEASURE: begin
        start_cycle = rising;
        emit_result = rising;
        advance     = sample_valid_i && !rising && !at_max;
        saturate    = sample_valid_i && !rising && at_max;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      region_reg       <= 1'b0;
      have_result_reg  <= 1'b0;
      count_reg        <= '0;
      run_min_reg      <= '0;
      run_max_reg      <= '0;
      result_valid_reg <= 1'b0;
      period_reg       <= '0;
      max_reg          <= '0;
      min_reg          <= '0;
      pk_pk_reg        <= '0;
      locked_reg       <= 1'b0;
      overflow_reg     <= 1'b0;
    end else begin
      result_valid_reg <= emit_result;
      if (sample_valid_i) begin
        if (is_high)     region_reg <= 1'b1;
        else if (is_low) region_reg <= 1'b0;
      end
      // The event sample opens the next cycle, so it seeds count and extremes.
      if (start_cycle) begin
        count_reg   <= CNT_WIDTH'(1);
        run_min_reg <= sample_i;
        run_max_reg <= sample_i;
      end else if (advance) begin
        count_reg <= count_reg + 1'b1;
        if (sample_ext < ext(run_min_reg)) run_min_reg <= sample_i;
        if (sample_ext > ext(run_max_reg)) run_max_reg <= sample_i;
      end
      if (emit_result) begin
        period_reg      <= count_reg;
        max_reg         <= run_max_reg;
        min_reg         <= run_min_reg;
        pk_pk_reg       <= run_max_reg - run_min_reg;
        locked_reg      <= (count_reg == period_reg) && have_result_reg;
        have_result_reg <= 1'b1;
      end
      if (saturate) begin
        overflow_reg    <= 1'b1;
        locked_reg      <= 1'b0;
        have_result_reg <= 1'b0;
      end
    end
  end

  assign result_valid_o = result_valid_reg;
  assign period_o       = period_reg;
  assign max_o          = max_reg;
  assign min_o          = min_reg;
  assign pk_pk_o        = pk_pk_reg;
  assign locked_o       = locked_reg;
  assign overflow_o     = overflow_reg;

endmodule
